// File: rtl/param_alu_pkg.sv
// Shared opcode values, FSM state encoding and width helpers for param_alu.
// Latency: none (package only).
// Backpressure: none (package only).
package param_alu_pkg;

    // Operation select values carried on Opcode
    localparam logic [2:0] OP_SLT = 3'b000;  // unsigned A < B -> 1/0
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    // Control FSM: EXEC covers every single-cycle op, MUL waits on the iterative multiplier
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2
    } state_t;

    // Ceiling log2, usable in constant expressions (shift-amount and counter widths)
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/param_alu_mul.sv
// Iterative shift-add multiplier, one multiplier bit consumed per cycle.
// Latency: start at edge k, done high in the cycle before edge k+WIDTH; product valid with done.
// Backpressure: start is ignored while busy; no stall once running, RST aborts.
module param_alu_mul
    import param_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [2*WIDTH-1:0] step;

    // One shift-add iteration per cycle; the final iteration is presented combinationally
    // on product so the parent can register it on the same edge the count expires.
    always_comb begin
        step     = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (busy_q) begin
            acc_d    = step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
                busy_d = 1'b0;
            end
        end else if (start) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end
    end

    // Iteration state registers, cleared asynchronously so a reset aborts cleanly
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign done    = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign product = step;

endmodule

// File: rtl/param_alu.sv
// Parameterised ALU: captures operands on Enable, single-cycle ops plus optional iterative multiply.
// Latency: result and Done at edge k+1 (single-cycle ops) or edge k+WIDTH (multiply).
// Backpressure: Busy high while executing; Enable and operand changes are ignored until IDLE.
module param_alu
    import param_alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int MUL_EN = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Enable,
    input  logic [WIDTH-1:0] Data_A,
    input  logic [WIDTH-1:0] Data_B,
    input  logic [2:0]       Opcode,
    output logic             Busy,
    output logic             Done,
    output logic             CF,
    output logic             ZF,
    output logic [WIDTH-1:0] Results
);

    localparam int SHW = clog2(WIDTH);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               cf_q, cf_d;
    logic               zf_q, zf_d;
    logic               done_q, done_d;

    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH-1:0]   exec_res;
    logic               exec_cf;
    logic [WIDTH:0]     add_full;
    logic [WIDTH:0]     sub_full;
    logic [WIDTH:0]     shl_full;
    logic [SHW-1:0]     shamt;

    // Single-cycle datapath on the captured operands; the extra top bit of each
    // widened result is the carry, borrow or last bit shifted out.
    always_comb begin
        shamt    = b_q[SHW-1:0];
        add_full = {1'b0, a_q} + {1'b0, b_q};
        sub_full = {1'b0, a_q} - {1'b0, b_q};
        shl_full = {1'b0, a_q} << shamt;
        exec_res = '0;
        exec_cf  = 1'b0;
        case (op_q)
            OP_SLT: exec_res = WIDTH'(a_q < b_q);
            OP_ADD: begin
                exec_res = add_full[WIDTH-1:0];
                exec_cf  = add_full[WIDTH];
            end
            OP_AND: exec_res = a_q & b_q;
            OP_OR:  exec_res = a_q | b_q;
            OP_SUB: begin
                exec_res = sub_full[WIDTH-1:0];
                exec_cf  = sub_full[WIDTH];
            end
            OP_XOR: exec_res = a_q ^ b_q;
            OP_SHL: begin
                exec_res = shl_full[WIDTH-1:0];
                exec_cf  = shl_full[WIDTH];
            end
            // Multiply only lands here when it is compiled out: result 0, CF 0
            default: begin
                exec_res = '0;
                exec_cf  = 1'b0;
            end
        endcase
    end

    // Control FSM: capture in IDLE, complete in EXEC or when the multiplier finishes
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        res_d     = res_q;
        cf_d      = cf_q;
        zf_d      = zf_q;
        done_d    = 1'b0;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Enable) begin
                    a_d  = Data_A;
                    b_d  = Data_B;
                    op_d = Opcode;
                    if ((Opcode == OP_MUL) && (MUL_EN != 0)) begin
                        mul_start = 1'b1;
                        state_d   = ST_MUL;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                res_d   = exec_res;
                cf_d    = exec_cf;
                zf_d    = (exec_res == '0);
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_MUL: begin
                if (mul_done) begin
                    res_d   = mul_product[WIDTH-1:0];
                    cf_d    = |mul_product[2*WIDTH-1:WIDTH];
                    zf_d    = (mul_product[WIDTH-1:0] == '0);
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (!mul_busy) begin
                    // Multiplier idle without finishing: never expected, recover rather than hang
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, operand and result registers; reset leaves ZF=1 to match Results=0
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_SLT;
            res_q   <= '0;
            cf_q    <= 1'b0;
            zf_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            cf_q    <= cf_d;
            zf_q    <= zf_d;
            done_q  <= done_d;
        end
    end

    generate
        if (MUL_EN != 0) begin : g_mul
            // Multiplier loads straight from the ports on the capture edge
            param_alu_mul #(
                .WIDTH (WIDTH)
            ) u_mul (
                .CLK     (CLK),
                .RST     (RST),
                .start   (mul_start),
                .a       (Data_A),
                .b       (Data_B),
                .busy    (mul_busy),
                .done    (mul_done),
                .product (mul_product)
            );
        end else begin : g_nomul
            assign mul_busy    = 1'b0;
            assign mul_done    = 1'b0;
            assign mul_product = '0;
        end
    endgenerate

    assign Busy    = (state_q != ST_IDLE);
    assign Done    = done_q;
    assign CF      = cf_q;
    assign ZF      = zf_q;
    assign Results = res_q;

endmodule

// File: tb/tb_param_alu.sv
// Directed table-driven bench for param_alu at WIDTH=16 with multiply enabled.
// Latency: checks single-cycle completion at edge k+1 and multiply completion at edge k+16.
// Backpressure: exercises ignored requests while Busy and back-to-back issue on the Done cycle.
module tb_param_alu;
    import param_alu_pkg::*;

    logic        CLK;
    logic        RST;
    logic        Enable;
    logic [15:0] Data_A;
    logic [15:0] Data_B;
    logic [2:0]  Opcode;
    logic        Busy;
    logic        Done;
    logic        CF;
    logic        ZF;
    logic [15:0] Results;

    int total = 0;
    int bad   = 0;

    param_alu #(
        .WIDTH  (16),
        .MUL_EN (1)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .Enable  (Enable),
        .Data_A  (Data_A),
        .Data_B  (Data_B),
        .Opcode  (Opcode),
        .Busy    (Busy),
        .Done    (Done),
        .CF      (CF),
        .ZF      (ZF),
        .Results (Results)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        cf;
        logic        zf;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Issue one op from IDLE; returns edges until Done (capped) and Busy-high samples seen
    task automatic do_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         output int lat, output int bcnt);
        Opcode = op;
        Data_A = a;
        Data_B = b;
        Enable = 1'b1;
        @(posedge CLK); #1;
        Enable = 1'b0;
        lat  = 0;
        bcnt = 0;
        while (lat < 40) begin
            if (Busy) bcnt++;
            @(posedge CLK); #1;
            lat++;
            if (Done) break;
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        int n;
        int pulses;

        vecs[0]  = '{OP_ADD, 16'h6464, 16'h4646, 16'hAAAA, 1'b0, 1'b0, 1};
        vecs[1]  = '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1};
        vecs[2]  = '{OP_AND, 16'h6464, 16'h4646, 16'h4444, 1'b0, 1'b0, 1};
        vecs[3]  = '{OP_OR,  16'h6464, 16'h4646, 16'h6666, 1'b0, 1'b0, 1};
        vecs[4]  = '{OP_XOR, 16'h6464, 16'h4646, 16'h2222, 1'b0, 1'b0, 1};
        vecs[5]  = '{OP_SLT, 16'h6464, 16'h4646, 16'h0000, 1'b0, 1'b1, 1};
        vecs[6]  = '{OP_SLT, 16'h4646, 16'h6464, 16'h0001, 1'b0, 1'b0, 1};
        vecs[7]  = '{OP_SUB, 16'h4646, 16'h6464, 16'hE1E2, 1'b1, 1'b0, 1};
        vecs[8]  = '{OP_SUB, 16'h5555, 16'h5555, 16'h0000, 1'b0, 1'b1, 1};
        vecs[9]  = '{OP_SHL, 16'h8001, 16'h0001, 16'h0002, 1'b1, 1'b0, 1};
        vecs[10] = '{OP_SHL, 16'h8001, 16'h0010, 16'h8001, 1'b0, 1'b0, 1};
        vecs[11] = '{OP_SHL, 16'h0003, 16'h000F, 16'h8000, 1'b1, 1'b0, 1};
        vecs[12] = '{OP_MUL, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1, 16};
        vecs[13] = '{OP_MUL, 16'h00FF, 16'h0003, 16'h02FD, 1'b0, 1'b0, 16};
        vecs[14] = '{OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16};
        vecs[15] = '{OP_MUL, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b1, 16};

        RST    = 1'b0;
        Enable = 1'b0;
        Data_A = 16'h0;
        Data_B = 16'h0;
        Opcode = 3'b000;

        // Asynchronous reset, checked before any clock edge
        #1 RST = 1'b1;
        #1;
        chk("reset_state", {27'd0, Busy, Done, CF, ZF, 1'b0}, {27'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        chk("reset_results", {16'd0, Results}, 32'd0);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b0;

        // Table-driven single ops
        for (int i = 0; i < 16; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].lat);
            chk($sformatf("v%0d_results", i), {16'd0, Results}, {16'd0, vecs[i].res});
            chk($sformatf("v%0d_flags", i), {30'd0, CF, ZF}, {30'd0, vecs[i].cf, vecs[i].zf});
            @(posedge CLK); #1;
            chk($sformatf("v%0d_done_width", i), {31'd0, Done}, 32'd0);
        end

        // Back-to-back: Enable held through EXEC with changed operands is ignored,
        // then accepted in the Done cycle
        Opcode = OP_ADD; Data_A = 16'h6464; Data_B = 16'h4646; Enable = 1'b1;
        @(posedge CLK); #1;
        Opcode = OP_XOR; Data_A = 16'h1234; Data_B = 16'hFFFF;
        @(posedge CLK); #1;
        chk("b2b_first", {15'd0, Done, Results}, {15'd0, 1'b1, 16'hAAAA});
        @(posedge CLK); #1;
        Enable = 1'b0;
        chk("b2b_accept", {31'd0, Busy}, 32'd1);
        @(posedge CLK); #1;
        chk("b2b_second", {15'd0, Done, Results}, {15'd0, 1'b1, 16'hEDCB});
        @(posedge CLK); #1;

        // Enable pulse with AND during a multiply must be ignored
        Opcode = OP_MUL; Data_A = 16'h00FF; Data_B = 16'h0003; Enable = 1'b1;
        @(posedge CLK); #1;
        Enable = 1'b0;
        n = 0;
        repeat (3) begin
            @(posedge CLK); #1;
            n++;
        end
        Opcode = OP_AND; Data_A = 16'hFFFF; Data_B = 16'hFFFF; Enable = 1'b1;
        @(posedge CLK); #1;
        n++;
        Enable = 1'b0;
        while (!Done && n < 40) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("mulign_latency", n, 16);
        chk("mulign_result", {15'd0, CF, Results}, {15'd0, 1'b0, 16'h02FD});
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            chk("mulign_after", {14'd0, Busy, Done, Results}, {14'd0, 1'b0, 1'b0, 16'h02FD});
        end

        // Idle with toggling inputs: outputs hold
        for (int i = 0; i < 10; i++) begin
            Data_A = 16'($urandom);
            Data_B = 16'($urandom);
            Opcode = 3'(i);
            Enable = 1'b0;
            @(posedge CLK); #1;
            chk("idle_hold", {13'd0, Done, CF, ZF, Results}, {13'd0, 1'b0, 1'b0, 1'b0, 16'h02FD});
        end

        // Reset during multiply cycle 5: immediate clear, no Done, then new op accepted
        Opcode = OP_MUL; Data_A = 16'h0100; Data_B = 16'h0100; Enable = 1'b1;
        @(posedge CLK); #1;
        Enable = 1'b0;
        repeat (4) @(posedge CLK);
        #3 RST = 1'b1;
        #1;
        chk("rst_mid_mul", {11'd0, Busy, Done, CF, ZF, 1'b0, Results},
            {11'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000});
        @(posedge CLK); #1;
        chk("rst_held", {29'd0, Busy, Done, ZF}, {29'd0, 1'b0, 1'b0, 1'b1});
        RST = 1'b0;
        Opcode = OP_ADD; Data_A = 16'h0001; Data_B = 16'h0001; Enable = 1'b1;
        @(posedge CLK); #1;
        Enable = 1'b0;
        chk("post_rst_accept", {31'd0, Busy}, 32'd1);
        @(posedge CLK); #1;
        chk("post_rst_add", {13'd0, Done, CF, ZF, Results}, {13'd0, 1'b1, 1'b0, 1'b0, 16'h0002});
        pulses = 0;
        repeat (16) begin
            @(posedge CLK); #1;
            if (Done) pulses++;
        end
        chk("aborted_mul_no_done", pulses, 0);
        chk("post_rst_hold", {16'd0, Results}, {16'd0, 16'h0002});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
